trigger_sequencer: RTL
======================

# trigger_sequencer

Parametrised multi-channel trigger front end for the counter datapath. It synchronises up to CHANNELS raw button/pulse inputs and detects qualifying edges under a selectable edge mode. Each accepted event produces a one-cycle increment pulse and, after a settle window, a one-cycle refresh pulse, followed by a debounce lockout. It also reports which channels caused the event and can optionally auto-repeat on held inputs.

## Interface
Parameters:
- CHANNELS, 6: number of trigger inputs (>=1)
- CNT_W, 13: width of the shared settle/debounce counter and the repeat counter
- SETTLE_CYCLES, 16: cycles between inc_clk and ref_clk (1 .. 2^CNT_W-1)
- DEBOUNCE_CYCLES, 8176: lockout cycles after ref_clk (1 .. 2^CNT_W-1)
- REPEAT_CYCLES, 8000: held cycles in READY before an auto-repeat (1 .. 2^CNT_W-1; used only with TRIG_AUTOREPEAT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- trigger  in  CHANNELS  raw asynchronous trigger inputs
- edge_mode  in  2  00 rising, 01 falling, 10 both, 11 reserved = rising; sampled only in READY
- inc_clk  out  1  one-cycle increment pulse
- ref_clk  out  1  one-cycle refresh pulse
- chan_mask  out  CHANNELS  channels that caused the most recent event; held until the next event
- busy  out  1  high whenever state != READY
- repeat_evt  out  1  high together with inc_clk when the event is an auto-repeat

## Operation
- Two-flop synchroniser per channel: raw -> q1 -> s. p is the previous-sample register; it updates (p <= s) only in READY.
- Hit vector in READY: rising s&~p; falling ~s&p; both s^p.
- States: READY, SETTLE, REFRESH, DEBOUNCE. cnt is the shared counter.
- READY with hit!=0: go to SETTLE, inc_clk<=1, chan_mask<=hit, cnt<=0, repeat_evt<=0.
- SETTLE: inc_clk<=0. If cnt==SETTLE_CYCLES-1, go to REFRESH with ref_clk<=1, cnt<=0. Otherwise cnt++.
- REFRESH: ref_clk<=0, go to DEBOUNCE, cnt<=0.
- DEBOUNCE: if cnt==DEBOUNCE_CYCLES-1, go to READY. Otherwise cnt++.
- Because p is frozen outside READY, an edge that occurs while busy and is still present at return to READY fires on the first READY cycle. An edge that reverts before then is dropped.
- Simultaneous hits on several channels produce one event, with all hit bits set in chan_mask.
- Reset (any state, including mid-operation): next cycle READY. q1, s, p, cnt, repeat counter, chan_mask, inc_clk, ref_clk and repeat_evt are all 0. busy is 0.
- A trigger already high when reset is released counts as a rising edge, because p=0.

## Timing
- Let trigger change before edge n. s is valid after edge n+1. inc_clk is high for the cycle after edge n+2 (call that cycle E+1).
- ref_clk is high exactly at cycle E+1+SETTLE_CYCLES.
- The first READY cycle is E+SETTLE_CYCLES+2+DEBOUNCE_CYCLES. The earliest next inc_clk is one cycle later.
- busy is high from cycle E+1 through the last DEBOUNCE cycle.
- inc_clk and ref_clk are never high in the same cycle. Each is exactly one cycle wide.

## Configuration
- TRIG_AUTOREPEAT_EN defined:
  - The repeat counter increments on each READY cycle with hit==0 and (s & chan_mask)!=0. It clears on any hit, on any cycle where (s & chan_mask)==0, and outside READY.
  - At count REPEAT_CYCLES-1 it raises an event exactly as a hit does: chan_mask<=s&chan_mask, repeat_evt<=1 with inc_clk.
  - The repeat period on a held input is SETTLE_CYCLES+DEBOUNCE_CYCLES+REPEAT_CYCLES+1 cycles.
  - Repeat applies to held-high levels in every edge_mode.
- TRIG_AUTOREPEAT_EN not defined: no repeat counter is built, repeat_evt is tied to 0, and a held input produces exactly one event.

## Test plan
All scenarios use CHANNELS=4, SETTLE_CYCLES=4, DEBOUNCE_CYCLES=20, REPEAT_CYCLES=10, edge_mode=00 unless stated.
- Rising edge ch1 before edge n -> inc_clk=1 at cycle n+3, chan_mask=4'b0010, ref_clk=1 at n+7, busy falls after n+27, and a second edge is accepted no earlier than n+28.
- ch0 and ch2 rise in the same cycle -> exactly one inc_clk/ref_clk pair, chan_mask=4'b0101.
- ch3 bounces 0/1 every cycle during SETTLE/DEBOUNCE and ends high -> single event at the first READY cycle, with no extra pulses during the lockout.
- edge_mode=01, ch2 falls -> event with chan_mask=4'b0100; a rising edge on ch2 under edge_mode=01 -> no event. edge_mode=10 -> both edges fire.
- Reset asserted one cycle into SETTLE -> next cycle all outputs 0, busy=0, and no ref_clk follows.
- TRIG_AUTOREPEAT_EN defined, ch0 held high -> inc_clk every 35 cycles with repeat_evt=1 on every repeat after the first. Releasing ch0 stops the events. Without the macro -> exactly one event.

Source files
------------

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: synchronised multi-channel edge trigger with settle,
// refresh and debounce lockout. Define TRIG_AUTOREPEAT_EN for auto-repeat.
module trigger_sequencer #(
  parameter int CHANNELS        = 6,
  parameter int CNT_W           = 13,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 8176,
  parameter int REPEAT_CYCLES   = 8000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [1:0]          edge_mode,
  output logic                inc_clk,
  output logic                ref_clk,
  output logic [CHANNELS-1:0] chan_mask,
  output logic                busy,
  output logic                repeat_evt
);

  typedef enum logic [1:0] {
    READY,
    SETTLE,
    REFRESH,
    DEBOUNCE
  } state_t;

  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  if (CHANNELS < 1 ||
      SETTLE_CYCLES < 1 ||
      SETTLE_CYCLES >= 2**CNT_W ||
      DEBOUNCE_CYCLES < 1 ||
      DEBOUNCE_CYCLES >= 2**CNT_W ||
      REPEAT_CYCLES < 1 ||
      REPEAT_CYCLES >= 2**CNT_W) begin : g_param_chk
    $error("trigger_sequencer: parameter out of range");
  end

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [CHANNELS-1:0] q1, s, p;
  logic [CHANNELS-1:0] hit, held;
  logic [CHANNELS-1:0] mask_nx;
  logic                inc_nx, ref_nx;
  logic                rpt_fire;

  assign busy = (state != READY);
  assign held = s & chan_mask;

  // two-flop synchroniser per channel
  always_ff @(posedge clk) begin
    if (reset) begin
      q1 <= '0;
      s  <= '0;
    end else begin
      q1 <= trigger;
      s  <= q1;
    end
  end

  // previous sample frozen while busy so edges during lockout are held
  always_ff @(posedge clk) begin
    if (reset) begin
      p <= '0;
    end else if (state == READY) begin
      p <= s;
    end
  end

  // edge qualification; reserved mode falls back to rising
  always_comb begin
    unique case (edge_mode)
      2'b01:   hit = ~s & p;
      2'b10:   hit = s ^ p;
      default: hit = s & ~p;
    endcase
  end

`ifdef TRIG_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rpt;

  assign rpt_fire = (state == READY) &&
                    (hit == '0) &&
                    (held != '0) &&
                    (rpt == RPT_LAST);

  // counts READY cycles with a held masked channel and no new edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt <= '0;
    end else if (state != READY || hit != '0 ||
                 held == '0 || rpt_fire) begin
      rpt <= '0;
    end else begin
      rpt <= rpt + CNT_W'(1);
    end
  end

  // repeat flag accompanies the inc pulse of a repeat event
  always_ff @(posedge clk) begin
    if (reset) begin
      repeat_evt <= 1'b0;
    end else begin
      repeat_evt <= rpt_fire;
    end
  end
`else
  assign rpt_fire   = 1'b0;
  assign repeat_evt = 1'b0;
`endif

  // state, counter and output pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= READY;
      cnt       <= '0;
      inc_clk   <= 1'b0;
      ref_clk   <= 1'b0;
      chan_mask <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      inc_clk   <= inc_nx;
      ref_clk   <= ref_nx;
      chan_mask <= mask_nx;
    end
  end

  // next-state, counter and pulse decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    inc_nx   = 1'b0;
    ref_nx   = 1'b0;
    mask_nx  = chan_mask;
    unique case (state)
      READY: begin
        if (hit != '0 || rpt_fire) begin
          state_nx = SETTLE;
          inc_nx   = 1'b1;
          cnt_nx   = '0;
          mask_nx  = (hit != '0) ? hit : held;
        end
      end
      SETTLE: begin
        if (cnt == SET_LAST) begin
          state_nx = REFRESH;
          ref_nx   = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      REFRESH: begin
        state_nx = DEBOUNCE;
        cnt_nx   = '0;
      end
      DEBOUNCE: begin
        if (cnt == DEB_LAST) begin
          state_nx = READY;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = READY;
    endcase
  end

endmodule
